computer: RTL and testbench

COMPUTER -- requirements
Module: computer

---
 rtl/arch_defs_pkg.sv | 22 ++
 rtl/ram.sv | 20 ++
 rtl/register_nbit.sv | 14 +
 rtl/computer.sv | 91 +++++++++
 tb/tb_computer.sv | 125 ++++++++++++
 5 files changed

// File: rtl/arch_defs_pkg.sv
// arch_defs_pkg: widths, opcodes and control-state encoding for the accumulator CPU.
package arch_defs_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 8;
  localparam logic [DATA_WIDTH-1:0] OP_NOP  = 8'h00;
  localparam logic [DATA_WIDTH-1:0] OP_LDA  = 8'h10;
  localparam logic [DATA_WIDTH-1:0] OP_LDI  = 8'h11;
  localparam logic [DATA_WIDTH-1:0] OP_STA  = 8'h20;
  localparam logic [DATA_WIDTH-1:0] OP_ADD  = 8'h30;
  localparam logic [DATA_WIDTH-1:0] OP_SUB  = 8'h31;
  localparam logic [DATA_WIDTH-1:0] OP_JMP  = 8'h40;
  localparam logic [DATA_WIDTH-1:0] OP_OUTA = 8'h50;
  localparam logic [DATA_WIDTH-1:0] OP_OUTM = 8'h51;
  localparam logic [DATA_WIDTH-1:0] OP_HLT  = 8'hFF;
  typedef enum logic [2:0] {FETCH, DECODE, OPERAND, MEMREAD, EXECUTE, HALT} state_e;
  function automatic logic reads_mem(input logic [DATA_WIDTH-1:0] op);
    return op inside {OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_OUTM};
  endfunction
  function automatic logic has_operand(input logic [DATA_WIDTH-1:0] op);
    return reads_mem(op) || op == OP_LDI || op == OP_JMP;
  endfunction
endpackage

// File: rtl/ram.sv
// ram: unified program/data memory, synchronous write and 1-cycle registered read.
module ram
  import arch_defs_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
  always_ff @(posedge clk_i) begin
    if (we_i) mem[addr_i] <= wdata_i;
    rdata_o <= mem[addr_i];
  end
  task automatic dump();
    for (int i = 0; i < (1 << ADDR_WIDTH); i++)
      if (mem[i] != '0) $display("mem[%02h] = %02h", i, mem[i]);
  endtask
endmodule

// File: rtl/register_nbit.sv
// register_nbit: loadable data register with synchronous active-low reset.
module register_nbit
  import arch_defs_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic [DATA_WIDTH-1:0] latched_data
);
  always_ff @(posedge clk_i)
    if (!rst_ni) latched_data <= '0;
    else if (load_i) latched_data <= d_i;
endmodule

// File: rtl/computer.sv
// computer: multi-cycle accumulator CPU over a unified RAM.
// Optional COMPUTER_TRACE_EN prints PC/opcode/A per EXECUTE and HALT on entry.
module computer
  import arch_defs_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  output logic [DATA_WIDTH-1:0] out_val
);
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, addr;
  logic [DATA_WIDTH-1:0] ir_q, ir_d, opr_q, opr_d, rdata, a_val, a_d, out_d;
  logic                  a_ld, out_ld, we, halt, exec;
  ram u_ram (
    .clk_i  (clk),
    .we_i   (we),
    .addr_i (addr),
    .wdata_i(a_val),
    .rdata_o(rdata)
  );
  register_nbit u_register_A (
    .clk_i       (clk),
    .rst_ni      (reset),
    .load_i      (a_ld),
    .d_i         (a_d),
    .latched_data(a_val)
  );
  register_nbit u_register_OUT (
    .clk_i       (clk),
    .rst_ni      (reset),
    .load_i      (out_ld),
    .d_i         (out_d),
    .latched_data(out_val)
  );
  always_ff @(posedge clk)
    if (!reset) begin
      state_q <= FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      opr_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      opr_q   <= opr_d;
    end
  // DECODE prefetches the operand byte; MEMREAD/EXECUTE address memory via the operand.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    opr_d   = opr_q;
    exec    = state_q == EXECUTE;
    halt    = state_q == HALT;
    addr    = state_q == DECODE ? pc_q + 1'b1
            : (state_q == MEMREAD || exec) ? ADDR_WIDTH'(opr_q) : pc_q;
    case (state_q)
      FETCH:   state_d = DECODE;
      DECODE: begin
        ir_d    = rdata;
        pc_d    = pc_q + 1'b1;
        state_d = has_operand(rdata) ? OPERAND : EXECUTE;
      end
      OPERAND: begin
        opr_d   = rdata;
        pc_d    = pc_q + 1'b1;
        state_d = reads_mem(ir_q) ? MEMREAD : EXECUTE;
      end
      MEMREAD: state_d = EXECUTE;
      EXECUTE: begin
        pc_d    = ir_q == OP_JMP ? ADDR_WIDTH'(opr_q) : pc_q;
        state_d = ir_q == OP_HLT ? HALT : FETCH;
      end
      default: state_d = HALT;
    endcase
    a_ld   = exec && ir_q inside {OP_LDA, OP_LDI, OP_ADD, OP_SUB, OP_OUTM};
    a_d    = ir_q == OP_LDI ? opr_q
           : ir_q == OP_ADD ? a_val + rdata
           : ir_q == OP_SUB ? a_val - rdata : rdata;
    out_ld = exec && ir_q inside {OP_OUTA, OP_OUTM};
    out_d  = ir_q == OP_OUTA ? a_val : rdata;
    we     = reset && exec && ir_q == OP_STA;
  end
`ifdef COMPUTER_TRACE_EN
  always_ff @(posedge clk)
    if (reset) begin
      if (exec) $display("PC=%02h OP=%02h A=%02h", pc_q, ir_q, a_val);
      if (state_d == HALT && !halt) $display("HALT");
    end
`endif
endmodule

// File: tb/tb_computer.sv
// tb_computer: directed programs with hand-computed results for the accumulator CPU.
module tb_computer;
  import arch_defs_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [DATA_WIDTH-1:0] out_val;
  int n_checks = 0;
  int n_fail = 0;
  int cyc;
  logic [7:0] pc_s, a_s, o_s;
  computer dut (.clk(clk), .reset(reset), .out_val(out_val));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic load(input logic [7:0] prog []);
    reset = 1'b0;
    for (int i = 0; i < 256; i++) dut.u_ram.mem[i] = 8'h00;
    foreach (prog[i]) dut.u_ram.mem[i] = prog[i];
  endtask
  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask
  task automatic run_to_halt(input int max, output int n);
    n = 0;
    while (!dut.halt && n < max) begin
      @(negedge clk);
      n++;
    end
    check("halt_reached", dut.halt, 1);
  endtask
  task automatic wait_state(input state_e s, input logic [7:0] op, input int max);
    int n = 0;
    while (!(dut.state_q == s && dut.ir_q == op) && n < max) begin
      @(negedge clk);
      n++;
    end
    check("state_reached", n < max, 1);
  endtask
  initial begin
    @(negedge clk);
    load('{8'h51, 8'h04, 8'hFF, 8'h00, 8'h0A});
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_A", dut.u_register_A.latched_data, 8'h00);
    check("rst_OUT", dut.u_register_OUT.latched_data, 8'h00);
    check("rst_out_val", out_val, 8'h00);
    check("rst_pc", dut.pc_q, 8'h00);
    check("rst_ir", dut.ir_q, 8'h00);
    check("rst_state", dut.state_q, FETCH);
    check("rst_halt", dut.halt, 0);
    reset = 1'b1;
    run_to_halt(50, cyc);
    check("outm_cycles", cyc, 8);
    check("outm_A", dut.u_register_A.latched_data, 8'h0A);
    check("outm_OUT", dut.u_register_OUT.latched_data, 8'h0A);
    check("outm_out_val", out_val, 8'h0A);
    check("outm_pc", dut.pc_q, 8'h03);
    load('{8'h10, 8'h10, 8'h30, 8'h11, 8'h50, 8'hFF});
    dut.u_ram.mem[8'h10] = 8'h05;
    dut.u_ram.mem[8'h11] = 8'h07;
    do_reset();
    run_to_halt(100, cyc);
    check("add_cycles", cyc, 16);
    check("add_out_val", out_val, 8'h0C);
    check("add_A", dut.u_register_A.latched_data, 8'h0C);
    load('{8'h11, 8'h03, 8'h31, 8'h10, 8'h50, 8'hFF});
    dut.u_ram.mem[8'h10] = 8'h05;
    do_reset();
    run_to_halt(100, cyc);
    check("sub_cycles", cyc, 15);
    check("sub_A", dut.u_register_A.latched_data, 8'hFE);
    check("sub_out_val", out_val, 8'hFE);
    load('{8'h11, 8'h2A, 8'h20, 8'h20, 8'h40, 8'h07, 8'hFF, 8'h10, 8'h20, 8'h51, 8'h20, 8'hFF});
    do_reset();
    run_to_halt(200, cyc);
    check("jmp_mem20", dut.u_ram.mem[8'h20], 8'h2A);
    check("jmp_A", dut.u_register_A.latched_data, 8'h2A);
    check("jmp_out_val", out_val, 8'h2A);
    check("jmp_skip_pc", dut.pc_q, 8'h0C);
    pc_s = dut.pc_q;
    a_s = dut.u_register_A.latched_data;
    o_s = out_val;
    repeat (20) @(negedge clk);
    check("hold_pc", dut.pc_q, pc_s);
    check("hold_A", dut.u_register_A.latched_data, a_s);
    check("hold_out_val", out_val, o_s);
    check("hold_halt", dut.halt, 1);
    check("hold_mem20", dut.u_ram.mem[8'h20], 8'h2A);
    reset = 1'b0;
    @(negedge clk);
    check("halt_rst_pc", dut.pc_q, 8'h00);
    check("halt_rst_halt", dut.halt, 0);
    check("halt_rst_out_val", out_val, 8'h00);
    load('{8'h51, 8'h04, 8'hFF, 8'h00, 8'h0A});
    do_reset();
    wait_state(MEMREAD, 8'h51, 20);
    reset = 1'b0;
    @(negedge clk);
    check("abort_A", dut.u_register_A.latched_data, 8'h00);
    check("abort_OUT", out_val, 8'h00);
    check("abort_pc", dut.pc_q, 8'h00);
    check("abort_state", dut.state_q, FETCH);
    reset = 1'b1;
    run_to_halt(50, cyc);
    check("abort_cycles", cyc, 8);
    check("abort_final_A", dut.u_register_A.latched_data, 8'h0A);
    check("abort_final_OUT", out_val, 8'h0A);
    load('{8'h11, 8'h2A, 8'h20, 8'h20, 8'hFF});
    do_reset();
    wait_state(EXECUTE, 8'h20, 30);
    reset = 1'b0;
    @(negedge clk);
    check("abort_sta_mem20", dut.u_ram.mem[8'h20], 8'h00);
    check("abort_sta_A", dut.u_register_A.latched_data, 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
